piso_frame_serializer: RTL and testbench

- Downstream neighbour of the serial-in/parallel-out window buffer.
- Accepts one frame of NDATA parallel words under a valid/ready handshake and replays it as a serial word stream under a second valid/ready handshake.
- Element 0 is emitted first. This matches the buffer's layout: oldest word at index 0, newest at NDATA-1. A SIPO->PISO round trip therefore preserves word order.
- Sits between the window buffer and any word-serial consumer (UART/FIFO/bus writer).

---
 rtl/piso_frame_serializer_pkg.sv | 16 +
 rtl/piso_frame_serializer.sv | 117 +++++++++++
 tb/tb_piso_frame_serializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_frame_serializer_pkg.sv
// Shared types and helpers for word-serial handshake stages.
//   hs_state_e  : two-state handshake FSM encoding (IDLE, SEND)
//   clog2_min1  : counter width for n items, never narrower than one bit
package piso_frame_serializer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } hs_state_e;

    // Width needed to index n items; a single-item counter still needs one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer.
// Captures NDATA words on an upstream valid/ready handshake and replays them,
// element 0 first, as a word stream under a downstream valid/ready handshake.
// Ports:
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_valid, i_data      : upstream frame (NDATA words), o_ready accepts it
//   o_ready              : combinational; frame accepted when i_valid && o_ready
//   o_valid, o_data      : current serial word (registered)
//   o_last               : current word is element NDATA-1 (registered)
//   i_ready              : downstream takes the word when o_valid && i_ready
module piso_frame_serializer
    import piso_frame_serializer_pkg::*;
#(
    parameter int unsigned BIT   = 8,
    parameter int unsigned NDATA = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    input  logic [BIT-1:0] i_data [0:NDATA-1],
    output logic           o_ready,
    output logic           o_valid,
    output logic [BIT-1:0] o_data,
    output logic           o_last,
    input  logic           i_ready
);

    localparam int unsigned    CW       = clog2_min1(NDATA);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NDATA - 1);

    hs_state_e      state;
    hs_state_e      state_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic [BIT-1:0] frame [0:NDATA-1];

    logic           accept;
    logic           xfer;
    logic           valid_n;
    logic           last_n;
    logic [BIT-1:0] data_n;

    // Ready in IDLE, or in SEND exactly when the last word is leaving, so
    // back-to-back frames stream without a bubble.
    assign o_ready = !i_rst && ((state == IDLE) || (o_last && i_ready));
    assign accept  = o_ready && i_valid;
    assign xfer    = o_valid && i_ready;

    // State, counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            o_valid <= valid_n;
            o_last  <= last_n;
            o_data  <= data_n;
        end
    end

    // Frame register: written only on an upstream handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame <= '{default: '0};
        end else if (accept) begin
            frame <= i_data;
        end
    end

    // Next state, counter and the values the output registers will hold.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        valid_n = 1'b0;
        last_n  = 1'b0;
        data_n  = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SEND;
                    cnt_n   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (cnt != LAST_IDX) begin
                        cnt_n = cnt + CW'(1);
                    end else if (accept) begin
                        cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // A fresh capture lands in the frame register on the same edge, so the
        // first word comes straight from i_data.
        valid_n = (state_n == SEND);
        if (valid_n) begin
            last_n = (cnt_n == LAST_IDX);
            data_n = accept ? i_data[0] : frame[cnt_n];
        end
    end

endmodule

// File: tb/tb_piso_frame_serializer.sv
module tb_piso_frame_serializer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NDATA=3 instance
    logic       rst3, v3, rdy3;
    logic [7:0] d3 [0:2];
    logic       ordy3, ov3, ol3;
    logic [7:0] od3;

    piso_frame_serializer #(.BIT(8), .NDATA(3)) dut3 (
        .i_clk  (clk),
        .i_rst  (rst3),
        .i_valid(v3),
        .i_data (d3),
        .o_ready(ordy3),
        .o_valid(ov3),
        .o_data (od3),
        .o_last (ol3),
        .i_ready(rdy3)
    );

    // NDATA=1 instance
    logic       rst1, v1, rdy1;
    logic [7:0] d1 [0:0];
    logic       ordy1, ov1, ol1;
    logic [7:0] od1;

    piso_frame_serializer #(.BIT(8), .NDATA(1)) dut1 (
        .i_clk  (clk),
        .i_rst  (rst1),
        .i_valid(v1),
        .i_data (d1),
        .o_ready(ordy1),
        .o_valid(ov1),
        .o_data (od1),
        .o_last (ol1),
        .i_ready(rdy1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] a, b, c;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic       er;
        logic       cd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic rst, input logic v,
                                input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic rdy, input logic ev, input logic [7:0] ed,
                                input logic el, input logic er, input logic cd);
        vec_t r;
        r.rst = rst; r.v = v; r.a = a; r.b = b; r.c = c; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.el = el; r.er = er; r.cd = cd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive3(input logic rst, input logic v, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c, input logic rdy);
        rst3 = rst; v3 = v; d3[0] = a; d3[1] = b; d3[2] = c; rdy3 = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic       r_rst, r_v, r_rdy;
    logic [7:0] ra, rb, rc;
    logic       exp_v, exp_l, exp_r;

    initial begin
        drive3(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        rst1 = 1'b1; v1 = 1'b0; d1[0] = 8'h00; rdy1 = 1'b0;

        // reset state (i_rst still high)
        next_cycle();
        @(negedge clk);
        chk("rst_valid", 32'(ov3), 32'd0);
        chk("rst_last",  32'(ol3), 32'd0);
        chk("rst_data",  32'(od3), 32'd0);
        chk("rst_ready", 32'(ordy3), 32'd0);
        next_cycle();
        drive3(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        chk("idle_ready", 32'(ordy3), 32'd1);
        chk("idle_valid", 32'(ov3), 32'd0);
        next_cycle();

        // rst v  a      b      c      rdy | ev ed     el er cd
        // single frame
        tv.push_back(mk(0, 1, 8'h11, 8'h22, 8'h33, 1, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h11, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h22, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h33, 1, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 0));
        // backpressure on the second word
        tv.push_back(mk(0, 1, 8'h11, 8'h22, 8'h33, 1, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h11, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h22, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h22, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h22, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h22, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h22, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h33, 1, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 0));
        // back-to-back A then B
        tv.push_back(mk(0, 1, 8'h01, 8'h02, 8'h03, 1, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 1, 8'h04, 8'h05, 8'h06, 1, 1, 8'h01, 0, 0, 1));
        tv.push_back(mk(0, 1, 8'h04, 8'h05, 8'h06, 1, 1, 8'h02, 0, 0, 1));
        tv.push_back(mk(0, 1, 8'h04, 8'h05, 8'h06, 1, 1, 8'h03, 1, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h04, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h05, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h06, 1, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 0));
        // upstream hold with a stall on A's last word; later i_data noise ignored
        tv.push_back(mk(0, 1, 8'h01, 8'h02, 8'h03, 1, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 1, 8'h04, 8'h05, 8'h06, 1, 1, 8'h01, 0, 0, 1));
        tv.push_back(mk(0, 1, 8'h04, 8'h05, 8'h06, 1, 1, 8'h02, 0, 0, 1));
        tv.push_back(mk(0, 1, 8'h04, 8'h05, 8'h06, 0, 1, 8'h03, 1, 0, 1));
        tv.push_back(mk(0, 1, 8'h04, 8'h05, 8'h06, 0, 1, 8'h03, 1, 0, 1));
        tv.push_back(mk(0, 1, 8'h04, 8'h05, 8'h06, 1, 1, 8'h03, 1, 1, 1));
        tv.push_back(mk(0, 0, 8'h07, 8'h08, 8'h09, 1, 1, 8'h04, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h09, 8'h09, 8'h09, 1, 1, 8'h05, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h06, 1, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 0));
        // mid-frame reset after 0x11 transfers, then a fresh frame
        tv.push_back(mk(0, 1, 8'h11, 8'h22, 8'h33, 1, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h11, 0, 0, 1));
        tv.push_back(mk(1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h22, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 1, 8'hA0, 8'hA1, 8'hA2, 1, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA0, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA1, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA2, 1, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 0));

        foreach (tv[i]) begin
            drive3(tv[i].rst, tv[i].v, tv[i].a, tv[i].b, tv[i].c, tv[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(ov3),   32'(tv[i].ev));
            chk($sformatf("vec%0d_last",  i), 32'(ol3),   32'(tv[i].el));
            chk($sformatf("vec%0d_ready", i), 32'(ordy3), 32'(tv[i].er));
            if (tv[i].cd)
                chk($sformatf("vec%0d_data", i), 32'(od3), 32'(tv[i].ed));
            next_cycle();
        end

        // randomized traffic against a queue model of the words still owed downstream
        q.delete();
        for (int k = 0; k < 600; k++) begin
            r_rst = ($urandom_range(0, 39) == 0);
            r_v   = 1'($urandom_range(0, 1));
            r_rdy = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
            drive3(r_rst, r_v, ra, rb, rc, r_rdy);
            @(negedge clk);
            exp_v = (q.size() > 0);
            exp_l = (q.size() == 1);
            exp_r = !r_rst && ((q.size() == 0) || ((q.size() == 1) && r_rdy));
            chk("rnd_valid", 32'(ov3),   32'(exp_v));
            chk("rnd_last",  32'(ol3),   32'(exp_l));
            chk("rnd_ready", 32'(ordy3), 32'(exp_r));
            if (exp_v) chk("rnd_data", 32'(od3), 32'(q[0]));
            if (r_rst) begin
                q.delete();
            end else begin
                if (exp_v && r_rdy) void'(q.pop_front());
                if (exp_r && r_v) begin
                    q.push_back(ra);
                    q.push_back(rb);
                    q.push_back(rc);
                end
            end
            next_cycle();
        end

        // NDATA=1: one frame per cycle, every word last
        drive3(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        chk("n1_rst_valid", 32'(ov1), 32'd0);
        chk("n1_rst_ready", 32'(ordy1), 32'd0);
        next_cycle();
        rst1 = 1'b0; v1 = 1'b1; d1[0] = 8'h5A; rdy1 = 1'b1;
        @(negedge clk);
        chk("n1_c0_ready", 32'(ordy1), 32'd1);
        chk("n1_c0_valid", 32'(ov1), 32'd0);
        next_cycle();
        d1[0] = 8'hC3;
        @(negedge clk);
        chk("n1_c1_valid", 32'(ov1), 32'd1);
        chk("n1_c1_data",  32'(od1), 32'h5A);
        chk("n1_c1_last",  32'(ol1), 32'd1);
        chk("n1_c1_ready", 32'(ordy1), 32'd1);
        next_cycle();
        v1 = 1'b0;
        @(negedge clk);
        chk("n1_c2_valid", 32'(ov1), 32'd1);
        chk("n1_c2_data",  32'(od1), 32'hC3);
        chk("n1_c2_last",  32'(ol1), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("n1_c3_valid", 32'(ov1), 32'd0);
        chk("n1_c3_last",  32'(ol1), 32'd0);
        chk("n1_c3_ready", 32'(ordy1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
